// File: rtl/fir_control_unit_pkg.sv
// Shared types and register-file map for the 4-tap FIR sequencer.
package fir_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_COPY  = 3'd1,
    OP_LOAD  = 3'd2,
    OP_CLEAR = 3'd3,
    OP_ADD   = 3'd4,
    OP_SUB   = 3'd5,
    OP_MUL   = 3'd6
  } op_t;

  // LOADC and LOADC_E decode identically; the split only remembers where to return.
  typedef enum logic [4:0] {
    S_IDLE, S_EIDLE,
    S_SHIFT3, S_SHIFT2, S_SHIFT1, S_LOADS, S_ZERO,
    S_MUL0, S_ADD0, S_MUL1, S_ADD1, S_MUL2, S_ADD2, S_MUL3, S_ADD3,
    S_LOADC, S_LOADC_E
  } state_t;

  localparam logic [3:0] ACC       = 4'd0;
  localparam logic [3:0] SAMP_BASE = 4'd1;
  localparam logic [3:0] COEF_BASE = 4'd5;
  localparam logic [3:0] TEMP      = 4'd9;

  function automatic logic [3:0] samp_reg(input logic [1:0] k);
    return SAMP_BASE + {2'b00, k};
  endfunction

  function automatic logic [3:0] coef_reg(input logic [1:0] k);
    return COEF_BASE + {2'b00, k};
  endfunction

endpackage

// File: rtl/fir_control_unit_if.sv
// Host request / datapath control bundle between the FIR sequencer and its neighbours.
interface fir_control_unit_if;
    logic       data_ready;
    logic       lc;
    logic       overflow;
    logic       cnt_up;
    logic       modwait;
    logic       err;
    logic [2:0] op;
    logic [3:0] src1;
    logic [3:0] src2;
    logic [3:0] dest;

    modport master (
        output data_ready, lc, overflow,
        input  cnt_up, modwait, err, op, src1, src2, dest
    );

    modport slave (
        input  data_ready, lc, overflow,
        output cnt_up, modwait, err, op, src1, src2, dest
    );
endinterface

// File: rtl/fir_control_unit_tap_index_counter.sv
// Wrapping coefficient-slot counter with synchronous active-low reset and enable.
module tap_index_counter #(
    parameter logic [1:0] LAST = 2'd3
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       en,
    output logic [1:0] count
);

    // NOTE: state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            count <= 2'd0;
        end else if (en) begin
            count <= (count == LAST) ? 2'd0 : count + 2'd1;
        end
    end

endmodule

// File: rtl/fir_control_unit.sv
// Moore sequencer issuing per-cycle opcodes and register selects to the FIR datapath.
module fir_control_unit
    import fir_ctrl_pkg::*;
#(
    parameter int NUM_TAPS = 4
) (
    input logic               clk,
    input logic               n_reset,
    fir_control_unit_if.slave bus
);

    localparam logic [1:0] LAST_TAP = 2'(NUM_TAPS - 1);

    state_t     state, state_next;
    logic [1:0] idx;
    op_t        op;

    tap_index_counter #(.LAST(LAST_TAP)) u_idx (
        .clk     (clk),
        .n_reset (n_reset),
        .en      (state == S_LOADC || state == S_LOADC_E),
        .count   (idx)
    );

    always_ff @(posedge clk) begin
        if (!n_reset) state <= S_IDLE;
        else          state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (bus.data_ready) state_next = S_SHIFT3;
                       else if (bus.lc)    state_next = S_LOADC;
            S_EIDLE:   if (bus.data_ready) state_next = S_SHIFT3;
                       else if (bus.lc)    state_next = S_LOADC_E;
            S_SHIFT3:  state_next = S_SHIFT2;
            S_SHIFT2:  state_next = S_SHIFT1;
            S_SHIFT1:  state_next = S_LOADS;
            S_LOADS:   state_next = S_ZERO;
            S_ZERO:    state_next = S_MUL0;
            S_MUL0:    state_next = S_ADD0;
            S_ADD0:    state_next = bus.overflow ? S_EIDLE : S_MUL1;
            S_MUL1:    state_next = S_ADD1;
            S_ADD1:    state_next = bus.overflow ? S_EIDLE : S_MUL2;
            S_MUL2:    state_next = S_ADD2;
            S_ADD2:    state_next = bus.overflow ? S_EIDLE : S_MUL3;
            S_MUL3:    state_next = S_ADD3;
            S_ADD3:    state_next = bus.overflow ? S_EIDLE : S_IDLE;
            S_LOADC:   state_next = S_IDLE;
            S_LOADC_E: state_next = S_EIDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_comb begin
        op          = OP_NOP;
        bus.src1    = ACC;
        bus.src2    = ACC;
        bus.dest    = ACC;
        bus.cnt_up  = 1'b0;
        bus.modwait = 1'b1;
        bus.err     = 1'b0;
        case (state)
            S_IDLE:   bus.modwait = 1'b0;
            S_EIDLE:  begin bus.modwait = 1'b0; bus.err = 1'b1; end
            S_SHIFT3: begin op = OP_COPY; bus.src1 = samp_reg(2'd2); bus.dest = samp_reg(2'd3); end
            S_SHIFT2: begin op = OP_COPY; bus.src1 = samp_reg(2'd1); bus.dest = samp_reg(2'd2); end
            S_SHIFT1: begin op = OP_COPY; bus.src1 = samp_reg(2'd0); bus.dest = samp_reg(2'd1); end
            S_LOADS:  begin op = OP_LOAD; bus.dest = SAMP_BASE; bus.cnt_up = 1'b1; end
            S_ZERO:   op = OP_CLEAR;
            S_MUL0:   begin op = OP_MUL; bus.src1 = samp_reg(2'd0); bus.src2 = coef_reg(2'd0); bus.dest = TEMP; end
            S_MUL1:   begin op = OP_MUL; bus.src1 = samp_reg(2'd1); bus.src2 = coef_reg(2'd1); bus.dest = TEMP; end
            S_MUL2:   begin op = OP_MUL; bus.src1 = samp_reg(2'd2); bus.src2 = coef_reg(2'd2); bus.dest = TEMP; end
            S_MUL3:   begin op = OP_MUL; bus.src1 = samp_reg(2'd3); bus.src2 = coef_reg(2'd3); bus.dest = TEMP; end
            S_ADD0, S_ADD1, S_ADD2, S_ADD3:
                      begin op = OP_ADD; bus.src2 = TEMP; end
            S_LOADC, S_LOADC_E:
                      begin op = OP_LOAD; bus.dest = coef_reg(idx); end
            default:  bus.modwait = 1'b0;
        endcase
    end

    assign bus.op = op;

endmodule

// File: tb/tb_fir_control_unit.sv
// Directed plus randomized bench for fir_control_unit against a queue-based reference model.
module tb_fir_control_unit;

    logic clk = 1'b0;
    logic n_reset = 1'b0;

    fir_control_unit_if bus ();

    fir_control_unit #(.NUM_TAPS(4)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] op;
        logic [3:0] src1;
        logic [3:0] src2;
        logic [3:0] dest;
        logic       cnt_up;
        logic       modwait;
        logic       err;
    } vec_t;

    int   vectors = 0;
    int   miscompares = 0;
    vec_t exp_v;
    vec_t q[$];
    bit   m_err = 1'b0;
    int   m_idx = 0;
    bit   check_en = 1'b0;

    function automatic vec_t mk(input int op, input int s1, input int s2, input int d,
                                input bit cu, input bit mw, input bit er);
        vec_t v;
        v.op      = 3'(op);
        v.src1    = 4'(s1);
        v.src2    = 4'(s2);
        v.dest    = 4'(d);
        v.cnt_up  = cu;
        v.modwait = mw;
        v.err     = er;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: what the controller shows during the cycle after each edge.
    always @(posedge clk) begin
        if (!n_reset) begin
            q.delete();
            m_err    = 1'b0;
            m_idx    = 0;
            exp_v    = mk(0, 0, 0, 0, 0, 0, 0);
            check_en = 1'b1;
        end else if (check_en) begin
            if (exp_v.modwait) begin
                if (exp_v.op == 3'd4 && bus.overflow) begin
                    q.delete();
                    m_err = 1'b1;
                    exp_v = mk(0, 0, 0, 0, 0, 0, 1);
                end else if (q.size() > 0) begin
                    exp_v = q.pop_front();
                end else begin
                    exp_v = mk(0, 0, 0, 0, 0, 0, m_err);
                end
            end else if (bus.data_ready) begin
                m_err = 1'b0;
                for (int s = 3; s >= 1; s--) q.push_back(mk(1, s, 0, s + 1, 0, 1, 0));
                q.push_back(mk(2, 0, 0, 1, 1, 1, 0));
                q.push_back(mk(3, 0, 0, 0, 0, 1, 0));
                for (int k = 0; k < 4; k++) begin
                    q.push_back(mk(6, 1 + k, 5 + k, 9, 0, 1, 0));
                    q.push_back(mk(4, 0, 9, 0, 0, 1, 0));
                end
                exp_v = q.pop_front();
            end else if (bus.lc) begin
                exp_v = mk(2, 0, 0, 5 + m_idx, 0, 1, 0);
                m_idx = (m_idx + 1) % 4;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en)
            check("cycle", 32'({bus.op, bus.src1, bus.src2, bus.dest, bus.cnt_up, bus.modwait, bus.err}),
                  32'(exp_v));
    end

    initial begin
        int mw;
        int cu;
        bus.data_ready = 1'b0;
        bus.lc         = 1'b0;
        bus.overflow   = 1'b0;
        n_reset        = 1'b0;
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_op", 32'(bus.op), 0);
        check("idle_flags", 32'({bus.cnt_up, bus.modwait, bus.err}), 0);
        check("idle_sel", 32'({bus.src1, bus.src2, bus.dest}), 0);

        for (int i = 0; i < 5; i++) begin
            bus.lc = 1'b1;
            @(negedge clk);
            bus.lc = 1'b0;
            check("loadc_dest", 32'(bus.dest), 5 + (i % 4));
            check("loadc_op", 32'({bus.op, bus.modwait}), {3'd2, 1'b1});
            repeat (2) @(negedge clk);
            check("loadc_ret", 32'(bus.modwait), 0);
        end

        // Full sample pass.
        mw = 0; cu = 0;
        bus.data_ready = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            bus.data_ready = 1'b0;
            mw += int'(bus.modwait);
            cu += int'(bus.cnt_up);
            if (i == 1) check("shift3", 32'({bus.op, bus.src1, bus.dest}), {3'd1, 4'd3, 4'd4});
            if (i == 4) check("cnt_up_cycle4", 32'(bus.cnt_up), 1);
            if (i == 12) check("mul3", 32'({bus.op, bus.src1, bus.src2, bus.dest}), {3'd6, 4'd4, 4'd8, 4'd9});
        end
        check("modwait_len", mw, 13);
        check("cnt_up_count", cu, 1);

        // Overflow during ADD1 aborts into EIDLE.
        bus.data_ready = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            bus.data_ready = 1'b0;
            bus.overflow   = (i == 9);
        end
        @(negedge clk);
        bus.overflow = 1'b0;
        check("ovf_eidle", 32'({bus.op, bus.modwait, bus.err}), {3'd0, 1'b0, 1'b1});
        @(negedge clk);
        check("ovf_no_mul2", 32'(bus.op), 0);
        bus.lc = 1'b1;
        @(negedge clk);
        bus.lc = 1'b0;
        check("eidle_loadc_dest", 32'(bus.dest), 6);
        @(negedge clk);
        check("eidle_return", 32'({bus.modwait, bus.err}), {1'b0, 1'b1});
        bus.data_ready = 1'b1;
        @(negedge clk);
        bus.data_ready = 1'b0;
        check("err_cleared", 32'({bus.op, bus.err}), {3'd1, 1'b0});
        repeat (14) @(negedge clk);

        // data_ready beats lc; busy requests dropped.
        cu = 0;
        bus.data_ready = 1'b1;
        bus.lc = 1'b1;
        @(negedge clk);
        bus.lc = 1'b0;
        bus.data_ready = 1'b0;
        check("dr_wins", 32'(bus.op), 1);
        for (int i = 2; i <= 15; i++) begin
            bus.data_ready = (i == 3 || i == 8);
            @(negedge clk);
            cu += int'(bus.cnt_up);
        end
        bus.data_ready = 1'b0;
        check("busy_ignored", cu, 1);
        bus.lc = 1'b1;
        @(negedge clk);
        bus.lc = 1'b0;
        check("idx_unchanged", 32'(bus.dest), 7);
        @(negedge clk);

        // Reset mid-pass during MUL2.
        bus.data_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            bus.data_ready = 1'b0;
        end
        check("at_mul2", 32'({bus.op, bus.src1}), {3'd6, 4'd3});
        n_reset = 1'b0;
        @(negedge clk);
        check("rst_mid", 32'({bus.op, bus.src1, bus.src2, bus.dest, bus.cnt_up, bus.modwait, bus.err}), 0);
        n_reset = 1'b1;
        bus.lc = 1'b1;
        @(negedge clk);
        bus.lc = 1'b0;
        check("rst_idx", 32'(bus.dest), 5);
        @(negedge clk);

        for (int c = 0; c < 4000; c++) begin
            bus.data_ready = ($urandom_range(7) == 0);
            bus.lc         = ($urandom_range(5) == 0);
            bus.overflow   = ($urandom_range(9) < 2);
            n_reset        = ($urandom_range(299) != 0);
            @(negedge clk);
        end
        bus.data_ready = 1'b0;
        bus.lc         = 1'b0;
        bus.overflow   = 1'b0;
        n_reset        = 1'b1;
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
